// File: rtl/argmax_sequencer.sv
// Sequential argmax over NUM_CLASSES signed scores served one at a time by a shared
// output-neuron datapath, with a per-score watchdog that aborts on a stalled response.
module argmax_sequencer #(
  parameter int NUM_CLASSES = 10,
  parameter int DATA_W      = 26,
  parameter int IDX_W       = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              GlobalReset,
  input  logic              start,
  output logic              score_req,
  output logic [IDX_W-1:0]  score_sel,
  input  logic              score_valid,
  input  logic [DATA_W-1:0] score_data,
  output logic              busy,
  output logic              done,
  output logic [IDX_W-1:0]  class_out,
  output logic [DATA_W-1:0] max_score,
  output logic              error
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int WDOG_W = $clog2(TIMEOUT_CYC + 1);

  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_CLASSES - 1);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYC - 1);
  localparam logic [DATA_W-1:0] MOST_NEG  = {1'b1, {(DATA_W-1){1'b0}}};

  logic [1:0]        state;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  run_idx;
  logic [DATA_W-1:0] run_max;
  logic [WDOG_W-1:0] wdog;

  // Candidate running maximum after folding in the current response.
  logic              take;
  logic [DATA_W-1:0] next_max;
  logic [IDX_W-1:0]  next_idx;
  logic              last_class;
  logic              wdog_expired;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    take         = 1'b0;
    next_max     = run_max;
    next_idx     = run_idx;
    last_class   = (idx == LAST_IDX);
    wdog_expired = (wdog == WDOG_LAST);
    // Index 0 always loads, so an all-most-negative input still reports class 0.
    if ((idx == '0) || ($signed(score_data) > $signed(run_max))) begin
      take = 1'b1;
    end
    if (take) begin
      next_max = score_data;
      next_idx = idx;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (GlobalReset) begin
      state     <= S_IDLE;
      idx       <= '0;
      run_idx   <= '0;
      run_max   <= '0;
      wdog      <= '0;
      class_out <= '0;
      max_score <= '0;
      error     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_REQ;
            idx     <= '0;
            run_max <= MOST_NEG;
            run_idx <= '0;
            wdog    <= '0;
          end
        end

        S_REQ: begin
          state <= S_WAIT;
        end

        S_WAIT: begin
          // A response in the expiry cycle still counts; the valid check comes first.
          if (score_valid) begin
            run_max <= next_max;
            run_idx <= next_idx;
            if (last_class) begin
              state     <= S_DONE;
              class_out <= next_idx;
              max_score <= next_max;
              error     <= 1'b0;
            end else begin
              state <= S_REQ;
              idx   <= idx + 1'b1;
              wdog  <= '0;
            end
          end else if (wdog_expired) begin
            state     <= S_DONE;
            class_out <= '1;
            max_score <= run_max;
            error     <= 1'b1;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Result registers load on the edge entering DONE, so they are visible with done.
  assign score_req = (state == S_REQ);
  assign score_sel = idx;
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);

endmodule
